spi: RTL and testbench

SPI -- requirements
Module: spi

---
 rtl/spi.sv | 75 +++++++
 tb/tb_spi.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/spi.sv
// SPI mode-0 slave with 8-bit frames, MSB first, driven entirely from the system clock.
// The external sck is sampled and its edges are detected locally; the byte in flight is tracked by bit_cnt.
module spi (
  input  logic       clk,
  input  logic       rst,
  input  logic       sck,
  input  logic       ss,
  input  logic       mosi,
  output logic       miso,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       busy
);

  logic       sck_q;
  logic       sck_q2;
  logic [2:0] bit_cnt;
  logic [7:0] rx_shift;
  logic [7:0] tx_shift;
  logic       rise;
  logic       fall;
  logic       idle;

  assign rise = sck_q & ~sck_q2;
  assign fall = ~sck_q & sck_q2;
  assign idle = ~sck_q & (bit_cnt == 3'd0);

  // sck sampling stages: sck_q feeds busy directly, sck_q2 only serves edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sck_q  <= 1'b0;
      sck_q2 <= 1'b0;
    end else begin
      sck_q  <= sck;
      sck_q2 <= sck_q;
    end
  end

  // receive path: deselect discards any partial byte
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt  <= 3'd0;
      rx_shift <= 8'h00;
    end else if (ss) begin
      bit_cnt  <= 3'd0;
      rx_shift <= 8'h00;
    end else if (rise) begin
      bit_cnt  <= bit_cnt + 3'd1;
      rx_shift <= {rx_shift[6:0], mosi};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout <= 8'h00;
    end else if (!ss && rise && (bit_cnt == 3'd7)) begin
      dout <= {rx_shift[6:0], mosi};
    end
  end

  // transmit path: reload from din while idle so bit 7 is ready before the first rise
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_shift <= 8'h00;
    end else if (idle) begin
      tx_shift <= din;
    end else if (!ss && fall) begin
      tx_shift <= {tx_shift[6:0], 1'b0};
    end
  end

  assign miso = ~ss & tx_shift[7];
  assign busy = sck_q | (bit_cnt != 3'd0);

endmodule

// File: tb/tb_spi.sv
// Bench for the spi slave: a behavioural SPI master drives frames and compares against
// expected bytes computed from the protocol rules (master gets din, slave gets the sent byte).
module tb_spi;

  localparam int HALF = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       sck;
  logic       ss;
  logic       mosi;
  logic       miso;
  logic [7:0] din;
  logic [7:0] dout;
  logic       busy;

  int n_chk  = 0;
  int n_fail = 0;

  spi dut (
    .clk  (clk),
    .rst  (rst),
    .sck  (sck),
    .ss   (ss),
    .mosi (mosi),
    .miso (miso),
    .din  (din),
    .dout (dout),
    .busy (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] din_v;
    logic [7:0] tx_v;
    logic [7:0] exp_rx;
    logic [7:0] exp_dout;
  } vec_t;

  typedef struct {
    logic [7:0] din_v;
    logic [7:0] tx_v;
  } frame_t;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One full mode-0 byte from the master side; optionally checks busy timing
  // and optionally changes din in the middle of the frame.
  task automatic xfer(input logic [7:0] tx, input logic chk_busy, input logic chg,
                      input logic [7:0] din_new, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      @(negedge clk);
      mosi = tx[i];
      repeat (HALF - 1) @(negedge clk);
      if (chk_busy && i == 7) check("busy_before_rise", {7'd0, busy}, 8'd0);
      sck   = 1'b1;
      rx[i] = miso;
      if (chk_busy && i == 7) begin
        @(posedge clk);
        #1;
        check("busy_after_rise", {7'd0, busy}, 8'd1);
      end
      repeat (HALF) @(negedge clk);
      if (chg && i == 6) din = din_new;
      sck = 1'b0;
      if (chk_busy) begin
        #1;
        check("busy_after_fall", {7'd0, busy}, 8'd1);
      end
      if (chk_busy && i == 0) begin
        @(posedge clk);
        #1;
        check("busy_after_last_fall", {7'd0, busy}, 8'd0);
      end
    end
    repeat (HALF) @(negedge clk);
  endtask

  task automatic partial(input logic [7:0] tx, input int nbits);
    for (int i = 7; i > 7 - nbits; i--) begin
      @(negedge clk);
      mosi = tx[i];
      repeat (HALF - 1) @(negedge clk);
      sck = 1'b1;
      repeat (HALF) @(negedge clk);
      sck = 1'b0;
    end
    repeat (HALF) @(negedge clk);
  endtask

  initial begin
    vec_t       vecs[4];
    frame_t     model_q[$];
    frame_t     f;
    logic [7:0] rx;
    logic [7:0] dn;
    logic       chg;

    vecs[0] = '{din_v: 8'hAA, tx_v: 8'hFF, exp_rx: 8'hAA, exp_dout: 8'hFF};
    vecs[1] = '{din_v: 8'hFF, tx_v: 8'h00, exp_rx: 8'hFF, exp_dout: 8'h00};
    vecs[2] = '{din_v: 8'h81, tx_v: 8'h7E, exp_rx: 8'h81, exp_dout: 8'h7E};
    vecs[3] = '{din_v: 8'hBE, tx_v: 8'hAA, exp_rx: 8'hBE, exp_dout: 8'hAA};

    rst  = 1'b0;
    sck  = 1'b0;
    ss   = 1'b1;
    mosi = 1'b0;
    din  = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_busy", {7'd0, busy}, 8'd0);
    check("reset_miso", {7'd0, miso}, 8'd0);
    check("reset_dout", dout, 8'h00);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // first byte after reset with busy timing
    ss = 1'b0;
    repeat (HALF) @(negedge clk);
    xfer(8'hAA, 1'b1, 1'b0, 8'h00, rx);
    check("s1_rx", rx, 8'h00);
    check("s1_dout", dout, 8'hAA);

    for (int k = 0; k < 4; k++) begin
      din = vecs[k].din_v;
      repeat (2) @(negedge clk);
      xfer(vecs[k].tx_v, 1'b0, 1'b0, 8'h00, rx);
      check($sformatf("vec%0d_rx", k), rx, vecs[k].exp_rx);
      check($sformatf("vec%0d_dout", k), dout, vecs[k].exp_dout);
    end

    ss = 1'b1;
    repeat (3) @(negedge clk);
    check("ss_high_busy", {7'd0, busy}, 8'd0);
    check("ss_high_miso", {7'd0, miso}, 8'd0);
    check("ss_high_dout", dout, 8'hAA);

    // deselect after three bits, then a clean frame
    ss  = 1'b0;
    din = 8'h11;
    repeat (HALF) @(negedge clk);
    partial(8'hC7, 3);
    check("partial_busy", {7'd0, busy}, 8'd1);
    ss = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_busy", {7'd0, busy}, 8'd0);
    check("abort_dout", dout, 8'hAA);
    din = 8'h3C;
    ss  = 1'b0;
    repeat (HALF) @(negedge clk);
    xfer(8'h5A, 1'b0, 1'b0, 8'h00, rx);
    check("s5_rx", rx, 8'h3C);
    check("s5_dout", dout, 8'h5A);

    // reset pulse in the middle of a byte, sck held high
    din = 8'h96;
    repeat (2) @(negedge clk);
    partial(8'hF0, 4);
    @(negedge clk);
    sck = 1'b1;
    repeat (HALF) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_mid_busy", {7'd0, busy}, 8'd0);
    check("rst_mid_miso", {7'd0, miso}, 8'd0);
    check("rst_mid_dout", dout, 8'h00);
    @(negedge clk);
    sck = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    din = 8'h69;
    repeat (HALF) @(negedge clk);
    xfer(8'hC3, 1'b1, 1'b0, 8'h00, rx);
    check("s6_rx", rx, 8'h69);
    check("s6_dout", dout, 8'hC3);

    // random back-to-back frames, din sometimes disturbed mid-frame
    for (int k = 0; k < 24; k++) begin
      f.din_v = 8'($urandom);
      f.tx_v  = 8'($urandom);
      dn      = 8'($urandom);
      chg     = 1'($urandom);
      model_q.push_back(f);
      din = f.din_v;
      repeat (2) @(negedge clk);
      xfer(f.tx_v, 1'b0, chg, dn, rx);
      f = model_q.pop_front();
      check($sformatf("rand%0d_rx", k), rx, f.din_v);
      check($sformatf("rand%0d_dout", k), dout, f.tx_v);
      if (k % 6 == 5) begin
        ss = 1'b1;
        repeat (3) @(negedge clk);
        check($sformatf("rand%0d_hold", k), dout, f.tx_v);
        ss = 1'b0;
        repeat (HALF) @(negedge clk);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
